// File: rtl/sdram_addr_req_gen_if.sv
// Wishbone host-side bus between the SDRAM request generator (master) and the controller port (slave).
interface sdram_addr_req_gen_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [24:0]       wb_addr_o;
  logic [3:0]        wb_sel_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_i;
  logic [DATA_W-1:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/sdram_addr_req_gen.sv
// Composes {row,bank,col} SDRAM addresses from a logical command and issues a burst of single-beat
// Wishbone transfers. Optional address self-check enabled by macro SDRAM_ADDR_CHECK_EN.
module sdram_addr_req_gen #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        cfg_colbits,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [11:0]       cmd_row,
  input  logic [1:0]        cmd_bank,
  input  logic [10:0]       cmd_col,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  sdram_addr_req_gen_if.master wb,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              done_o,
  output logic              err_o
`ifdef SDRAM_ADDR_CHECK_EN
  ,
  output logic              addr_mismatch_o
`endif
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} state_e;

  state_e              state_q;
  logic [11:0]         row_q;
  logic [1:0]          bank_q;
  logic [1:0]          colbits_q;
  logic [10:0]         col_q;
  logic [3:0]          len_q;
  logic [3:0]          beat_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                cmd_ready_q;
  logic                cyc_q;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [24:0]         addr_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                done_q;
  logic                err_q;

  logic [10:0]         acc_col_d;
  logic [24:0]         acc_addr_d;
  logic [10:0]         nxt_col_d;
  logic [24:0]         nxt_addr_d;
  logic                last_beat_d;
  logic                timeout_d;

  // Keep only the n = 8 + colbits column bits; higher column bits never reach the address.
  function automatic logic [10:0] col_mask(input logic [10:0] c, input logic [1:0] cb);
    return c & (11'h7FF >> (2'd3 - cb));
  endfunction

  function automatic logic [24:0] compose(input logic [11:0] r, input logic [1:0] b,
                                          input logic [10:0] c, input logic [1:0] cb);
    logic [24:0] a;
    unique case (cb)
      2'd0:    a = {3'b000, r, b, c[7:0]};
      2'd1:    a = {2'b00,  r, b, c[8:0]};
      2'd2:    a = {1'b0,   r, b, c[9:0]};
      default: a = {r, b, c};
    endcase
    return a;
  endfunction

  always_comb begin
    acc_col_d   = col_mask(cmd_col & 11'h7FC, cfg_colbits);
    acc_addr_d  = compose(cmd_row, cmd_bank, acc_col_d, cfg_colbits);
    nxt_col_d   = col_mask(col_q + 11'd4, colbits_q);
    nxt_addr_d  = compose(row_q, bank_q, nxt_col_d, colbits_q);
    last_beat_d = (beat_q == len_q);
    timeout_d   = (wait_q == WAIT_W'(TIMEOUT - 1));
  end

  // Burst sequencer; an ack on the final wait cycle still completes the beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      bank_q      <= '0;
      colbits_q   <= '0;
      col_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      dat_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= S_BUS;
            cmd_ready_q <= 1'b0;
            row_q       <= cmd_row;
            bank_q      <= cmd_bank;
            colbits_q   <= cfg_colbits;
            col_q       <= acc_col_d;
            len_q       <= cmd_len;
            beat_q      <= '0;
            wait_q      <= '0;
            cyc_q       <= 1'b1;
            we_q        <= cmd_we;
            sel_q       <= 4'hF;
            addr_q      <= acc_addr_d;
            dat_q       <= cmd_wdata;
          end
        end
        S_BUS: begin
          if (wb.wb_ack_i) begin
            if (!we_q) begin
              rd_data_q  <= wb.wb_dat_i;
              rd_valid_q <= 1'b1;
            end
            if (last_beat_d) begin
              state_q <= S_DONE;
              cyc_q   <= 1'b0;
              we_q    <= 1'b0;
              sel_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 4'd1;
              wait_q <= '0;
              col_q  <= nxt_col_d;
              addr_q <= nxt_addr_d;
              dat_q  <= dat_q + DATA_W'(1);
            end
          end else if (timeout_d) begin
            state_q <= S_ERR;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          cyc_q       <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = cyc_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_sel_o  = sel_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = dat_q;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

`ifdef SDRAM_ADDR_CHECK_EN
  logic [11:0] dec_row_c;
  logic [1:0]  dec_bank_c;
  logic [10:0] dec_col_c;
  logic        mismatch_q;

  // Decode the driven address back with the burst's latched column width.
  always_comb begin
    dec_row_c  = 12'(addr_q >> (5'd10 + {3'b000, colbits_q}));
    dec_bank_c = 2'(addr_q >> (5'd8 + {3'b000, colbits_q}));
    dec_col_c  = col_mask(addr_q[10:0], colbits_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mismatch_q <= 1'b0;
    end else if (cyc_q && ((dec_row_c != row_q) || (dec_bank_c != bank_q) ||
                           (dec_col_c[10:2] != col_q[10:2]))) begin
      mismatch_q <= 1'b1;
    end
  end

  assign addr_mismatch_o = mismatch_q;
`endif

endmodule
